// File: rtl/mem_wb_block.sv
// mem_wb_block: combined memory-access and write-back stage with internal byte-enable data RAM.
//   Optional feature macro: MEM_ALIGN_CHECK_EN (defined -> misaligned halfword/word requests fault;
//   undefined -> misaligned address bits are forced to natural alignment).
//   Inputs : clk_i, reset_i (async, active-high), stall_pipeline_i, mem_write_en_i, mem_read_en_i,
//            mem_size_i, mem_sign_ext_i, reg_file_write_en_i, reg_file_input_ctrl_sig_i,
//            reg_dest_addr_i, alu_result_i, store_data_i
//   Outputs: reg_file_write_en_o, reg_dest_addr_o, reg_data_o, mem_fault_o
module mem_wb_block #(
    parameter int MEM_DEPTH_WORDS = 256,
    parameter int WORD            = 32,
    parameter int ADDR_WIDTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  stall_pipeline_i,
    input  logic                  mem_write_en_i,
    input  logic                  mem_read_en_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_sign_ext_i,
    input  logic                  reg_file_write_en_i,
    input  logic                  reg_file_input_ctrl_sig_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  logic [WORD-1:0]       alu_result_i,
    input  logic [WORD-1:0]       store_data_i,
    output logic                  reg_file_write_en_o,
    output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
    output logic [WORD-1:0]       reg_data_o,
    output logic                  mem_fault_o
);
    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);

    logic [WORD-1:0]       mem [MEM_DEPTH_WORDS];
    logic [IDX_W-1:0]      idx;
    logic [1:0]            addr_lo_d;
    logic                  fault_d;
    logic [3:0]            be;
    logic [WORD-1:0]       wdata;
    logic                  ram_we;
    logic                  ram_re;

    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] dest_q;
    logic                  sel_q;
    logic [1:0]            size_q;
    logic                  sext_q;
    logic [1:0]            addr_lo_q;
    logic [WORD-1:0]       alu_q;
    logic                  fault_q;
    logic [WORD-1:0]       rdata_q;

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [WORD-1:0]       load_data;

    assign idx = alu_result_i[IDX_W+1:2];

    // Lane offset snapped to natural alignment; with the alignment check enabled
    // a misaligned request faults before this value can matter.
    always_comb begin
        addr_lo_d = mem_size_i == 2'b00 ? alu_result_i[1:0] :
                    mem_size_i == 2'b01 ? {alu_result_i[1], 1'b0} : 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
        fault_d   = (mem_read_en_i & mem_write_en_i) |
                    ((mem_read_en_i | mem_write_en_i) &
                     ((mem_size_i == 2'b01 & alu_result_i[0]) |
                      (mem_size_i[1] & alu_result_i[1:0] != 2'b00)));
`else
        fault_d   = mem_read_en_i & mem_write_en_i;
`endif
    end

    // Store data is replicated across lanes so each byte enable picks the right slice.
    always_comb begin
        wdata  = mem_size_i == 2'b00 ? {4{store_data_i[7:0]}} :
                 mem_size_i == 2'b01 ? {2{store_data_i[15:0]}} : store_data_i;
        be     = mem_size_i == 2'b00 ? 4'b0001 << addr_lo_d :
                 mem_size_i == 2'b01 ? (addr_lo_d[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        ram_we = ~stall_pipeline_i & mem_write_en_i & ~fault_d;
        ram_re = ~stall_pipeline_i & mem_read_en_i & ~fault_d;
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wen_q     <= 1'b0;
            dest_q    <= '0;
            sel_q     <= 1'b0;
            size_q    <= 2'b00;
            sext_q    <= 1'b0;
            addr_lo_q <= 2'b00;
            alu_q     <= '0;
            fault_q   <= 1'b0;
            rdata_q   <= '0;
        end else if (!stall_pipeline_i) begin
            wen_q     <= reg_file_write_en_i;
            dest_q    <= reg_dest_addr_i;
            sel_q     <= reg_file_input_ctrl_sig_i;
            size_q    <= mem_size_i;
            sext_q    <= mem_sign_ext_i;
            addr_lo_q <= addr_lo_d;
            alu_q     <= alu_result_i;
            fault_q   <= fault_d;
            if (ram_re) rdata_q <= mem[idx];
        end
    end

    always_comb begin
        byte_sel  = rdata_q[8*addr_lo_q +: 8];
        half_sel  = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_data = size_q == 2'b00 ? {{(WORD-8){sext_q & byte_sel[7]}}, byte_sel} :
                    size_q == 2'b01 ? {{(WORD-16){sext_q & half_sel[15]}}, half_sel} : rdata_q;
    end

    assign reg_file_write_en_o = wen_q & ~fault_q;
    assign reg_dest_addr_o     = dest_q;
    assign reg_data_o          = sel_q ? load_data : alu_q;
    assign mem_fault_o         = fault_q;
endmodule
